// File: rtl/window_column_feeder_if.sv
// Pixel-in / column-triple-out bundle for the 3-row window column feeder.
// The master side produces pixels; the slave side (the feeder) produces triples.
interface window_column_feeder_if;
  logic       in_valid;
  logic [7:0] in_pix;
  logic       out_valid;
  logic [7:0] col_top;
  logic [7:0] col_mid;
  logic [7:0] col_bot;
  logic [7:0] out_col;
  logic [7:0] out_row;
  logic       frame_done;

  modport master (
    output in_valid, in_pix,
    input  out_valid, col_top, col_mid, col_bot, out_col, out_row, frame_done
  );

  modport slave (
    input  in_valid, in_pix,
    output out_valid, col_top, col_mid, col_bot, out_col, out_row, frame_done
  );
endinterface

// File: rtl/window_column_feeder.sv
// Streams raster pixels and emits vertical 3-pixel columns (rows r-2, r-1, r)
// using two line buffers; one-cycle registered latency, no backpressure.
module window_column_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input logic                   clk,
  input logic                   rst,
  window_column_feeder_if.slave bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    lb1_q [IMG_W];
  logic [7:0]    lb2_q [IMG_W];

  logic          valid_q, done_q;
  logic [7:0]    top_q, mid_q, bot_q, ocol_q, orow_q;

  logic          last_col, last_row, emit;

  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));
  assign emit     = (row_q >= RW'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (bus.in_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (bus.in_valid) begin
        // Both buffers shift down one row at this column on the same edge.
        lb2_q[col_q] <= lb1_q[col_q];
        lb1_q[col_q] <= bus.in_pix;
        top_q        <= lb2_q[col_q];
        mid_q        <= lb1_q[col_q];
        bot_q        <= bus.in_pix;
        ocol_q       <= 8'(col_q);
        orow_q       <= 8'(row_q);
        valid_q      <= emit;
        done_q       <= emit && last_col && last_row;
      end else begin
        valid_q <= 1'b0;
        done_q  <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.frame_done = done_q;
  assign bus.col_top    = top_q;
  assign bus.col_mid    = mid_q;
  assign bus.col_bot    = bot_q;
  assign bus.out_col    = ocol_q;
  assign bus.out_row    = orow_q;
endmodule

// File: tb/tb_window_column_feeder.sv
// Directed bench for window_column_feeder on a 4x4 image: continuous, gapped,
// back-to-back, mid-frame reset and signed-extreme streams.
module tb_window_column_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  window_column_feeder_if bus ();

  window_column_feeder #(.IMG_W(4), .IMG_H(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input bit v, input int pix);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_pix   = 8'(pix);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_done"},  int'(bus.frame_done), 0);
    chk({tag, "_top"},   int'(bus.col_top), 0);
    chk({tag, "_mid"},   int'(bus.col_mid), 0);
    chk({tag, "_bot"},   int'(bus.col_bot), 0);
    chk({tag, "_col"},   int'(bus.out_col), 0);
    chk({tag, "_row"},   int'(bus.out_row), 0);
  endtask

  // Pixel p of a 4x4 frame sits at row p/4, col p%4; its triple is
  // (pix-8, pix-4, pix) because the stream values rise by one per pixel.
  task automatic run_frame(input string tag, input int base, input bit gaps);
    int triples;
    int pix;
    triples = 0;
    for (int p = 0; p < 16; p++) begin
      pix = base + p;
      push(1'b1, pix);
      chk({tag, "_valid"}, int'(bus.out_valid), (p >= 8) ? 1 : 0);
      chk({tag, "_done"},  int'(bus.frame_done), (p == 15) ? 1 : 0);
      if (bus.out_valid) begin
        triples++;
        chk({tag, "_top"}, int'(bus.col_top), (pix - 8) & 255);
        chk({tag, "_mid"}, int'(bus.col_mid), (pix - 4) & 255);
        chk({tag, "_bot"}, int'(bus.col_bot), pix & 255);
        chk({tag, "_col"}, int'(bus.out_col), p % 4);
        chk({tag, "_row"}, int'(bus.out_row), p / 4);
      end
      if (gaps) begin
        push(1'b0, 8'h5A);
        chk({tag, "_idle_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_idle_done"},  int'(bus.frame_done), 0);
        chk({tag, "_idle_bot"},   int'(bus.col_bot), pix & 255);
      end
    end
    chk({tag, "_triples"}, triples, 8);
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.in_pix   = 8'd55;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");

    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    run_frame("contig", 0, 1'b0);
    run_frame("b2b", -16, 1'b0);
    run_frame("gapped", 0, 1'b1);

    for (int p = 0; p < 10; p++) push(1'b1, p);
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_frame("after_rst", 0, 1'b0);

    push(1'b1, -128);
    for (int i = 0; i < 3; i++) push(1'b1, 0);
    push(1'b1, 127);
    for (int i = 0; i < 3; i++) push(1'b1, 0);
    push(1'b1, -1);
    chk("ext_valid", int'(bus.out_valid), 1);
    chk("ext_top",   int'(bus.col_top), 'h80);
    chk("ext_mid",   int'(bus.col_mid), 'h7F);
    chk("ext_bot",   int'(bus.col_bot), 'hFF);
    chk("ext_row",   int'(bus.out_row), 2);
    chk("ext_col",   int'(bus.out_col), 0);

    @(negedge clk);
    bus.in_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
